// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_ld;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       halted;
    logic [3:0] state;

    // Controller side: consumes instruction fields and flags, drives controls.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_ld, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_ctrl, halted, state
    );

    // Datapath side.
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_ld, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_ctrl, halted, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath: fetch, decode and sequence
// each instruction through 3-5 states, stalling on mem_ready, trapping unknown
// opcodes/functs into a sticky HALT.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          rst,
    multicycle_controller_if.master       bus
);
    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EX     = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       pc_ld;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       halted;

    // State register; reset always returns to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; reset masks every control output.
    always_comb begin
        state_d    = state_q;
        pc_ld      = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_ld    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE: state_d = (bus.funct == FN_JR) ? S_JR : S_R_EX;
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_d = S_I_EX;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                state_d   = S_R_WB;
                case (bus.funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: state_d  = S_HALT;
                endcase
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                state_d   = S_FETCH;
            end
            S_I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_ld     = bus.zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_ld   = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_src     = 2'b10;
                pc_ld      = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_src  = 2'b11;
                pc_ld   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (rst) begin
            pc_ld      = 1'b0;
            pc_src     = 2'b00;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_ctrl   = 3'b000;
            halted     = 1'b0;
        end
    end

    assign bus.pc_ld      = pc_ld;
    assign bus.pc_src     = pc_src;
    assign bus.i_or_d     = i_or_d;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.halted     = halted;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle state/control trace and compared cycle by cycle.
module tb_multicycle_controller;
    typedef struct packed {
        logic       pc_ld;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       halted;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
        logic       rdy;
        logic       z;
    } step_t;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2,
        MEM_RD = 4'd3, MEM_WB = 4'd4, MEM_WR = 4'd5, R_EX = 4'd6, R_WB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, I_EX = 4'd10, I_WB = 4'd11, JAL = 4'd12,
        JR = 4'd13, HALT = 4'd14;

    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000,
        OR_ = 3'b001, SLT = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    step_t q[$];

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctrl_t observe();
        ctrl_t c;
        c.pc_ld      = bus.pc_ld;
        c.pc_src     = bus.pc_src;
        c.i_or_d     = bus.i_or_d;
        c.mem_read   = bus.mem_read;
        c.mem_write  = bus.mem_write;
        c.ir_write   = bus.ir_write;
        c.reg_dst    = bus.reg_dst;
        c.mem_to_reg = bus.mem_to_reg;
        c.reg_write  = bus.reg_write;
        c.alu_src_a  = bus.alu_src_a;
        c.alu_src_b  = bus.alu_src_b;
        c.alu_ctrl   = bus.alu_ctrl;
        c.halted     = bus.halted;
        return c;
    endfunction

    // ALU function for a legal R-type funct; valid=0 for anything else.
    function automatic logic [2:0] r_alu(input logic [5:0] fn, output logic valid);
        valid = 1'b1;
        case (fn)
            6'b100000: return ADD;
            6'b100010: return SUB;
            6'b100100: return AND_;
            6'b100101: return OR_;
            6'b101010: return SLT;
            default: begin valid = 1'b0; return 3'b000; end
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input ctrl_t c, input logic rdy, input logic z);
        step_t s;
        s.st = st; s.c = c; s.rdy = rdy; s.z = z;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycle trace. Returns 1 if it traps.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                         input int fst, input int mst, output bit traps);
        ctrl_t c;
        logic  ok;
        logic [2:0] a;
        traps = 0;
        for (int i = 0; i <= fst; i++) begin
            c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_ctrl = ADD;
            if (i == fst) begin c.ir_write = 1; c.pc_ld = 1; end
            push(FETCH, c, logic'(i == fst), 1'($urandom));
        end
        c = '0; c.alu_src_b = 2'b11; c.alu_ctrl = ADD;
        push(DECODE, c, 1'($urandom), 1'($urandom));
        if (op == 6'b000000 && fn == 6'b001000) begin
            c = '0; c.pc_src = 2'b11; c.pc_ld = 1;
            push(JR, c, 1'($urandom), 1'($urandom));
        end else if (op == 6'b000000) begin
            a = r_alu(fn, ok);
            c = '0; c.alu_src_a = 1; c.alu_ctrl = a;
            push(R_EX, c, 1'($urandom), 1'($urandom));
            if (ok) begin
                c = '0; c.reg_write = 1; c.reg_dst = 2'b01;
                push(R_WB, c, 1'($urandom), 1'($urandom));
            end else traps = 1;
        end else if (op == 6'b100011 || op == 6'b101011) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = ADD;
            push(MEM_ADDR, c, 1'($urandom), 1'($urandom));
            for (int i = 0; i <= mst; i++) begin
                c = '0; c.i_or_d = 1;
                if (op == 6'b100011) c.mem_read = 1; else c.mem_write = 1;
                push((op == 6'b100011) ? MEM_RD : MEM_WR, c, logic'(i == mst), 1'($urandom));
            end
            if (op == 6'b100011) begin
                c = '0; c.reg_write = 1; c.mem_to_reg = 2'b01;
                push(MEM_WB, c, 1'($urandom), 1'($urandom));
            end
        end else if (op == 6'b000100) begin
            c = '0; c.alu_src_a = 1; c.alu_ctrl = SUB; c.pc_src = 2'b01; c.pc_ld = zf;
            push(BRANCH, c, 1'($urandom), zf);
        end else if (op == 6'b001000 || op == 6'b001010) begin
            c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
            c.alu_ctrl = (op == 6'b001010) ? SLT : ADD;
            push(I_EX, c, 1'($urandom), 1'($urandom));
            c = '0; c.reg_write = 1;
            push(I_WB, c, 1'($urandom), 1'($urandom));
        end else if (op == 6'b000010) begin
            c = '0; c.pc_src = 2'b10; c.pc_ld = 1;
            push(JUMP, c, 1'($urandom), 1'($urandom));
        end else if (op == 6'b000011) begin
            c = '0; c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
            c.pc_src = 2'b10; c.pc_ld = 1;
            push(JAL, c, 1'($urandom), 1'($urandom));
        end else traps = 1;
        if (traps) begin
            c = '0; c.halted = 1;
            for (int i = 0; i < 20; i++) push(HALT, c, 1'($urandom), 1'($urandom));
        end
    endtask

    // Reset while outputs are checked zero, then release just after the edge.
    task automatic do_reset(input logic [3:0] cur);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_state_hold", 32'(bus.state), 32'(cur));
        check("rst_ctrl_zero", 32'(observe()), 32'd0);
        @(posedge clk);
        #1;
        check("rst_state_fetch", 32'(bus.state), 32'(FETCH));
        check("rst_ctrl_zero2", 32'(observe()), 32'd0);
        rst = 1'b0;
    endtask

    // Run one instruction; abort_at >= 0 asserts reset in place of that step.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                       input int fst, input int mst, input int abort_at);
        bit traps;
        step_t s;
        q.delete();
        bus.opcode = op;
        bus.funct  = fn;
        build(op, fn, zf, fst, mst, traps);
        for (int i = 0; i < q.size(); i++) begin
            s = q[i];
            if (i == abort_at) begin
                do_reset(s.st);
                q.delete();
                return;
            end
            @(negedge clk);
            bus.mem_ready = s.rdy;
            bus.zero      = s.z;
            #1;
            check("state", 32'(bus.state), 32'(s.st));
            check("ctrl", 32'(observe()), 32'(s.c));
        end
        if (traps) do_reset(HALT);
    endtask

    localparam int N_OPS = 9;
    logic [5:0] ops [N_OPS] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
        6'b001000, 6'b001010, 6'b000010, 6'b000011, 6'b000000};
    localparam int N_FNS = 6;
    logic [5:0] fns [N_FNS] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
        6'b101010, 6'b001000};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("init_state", 32'(bus.state), 32'(FETCH));
        check("init_ctrl", 32'(observe()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(6'b000000, 6'b100000, 1'b0, 0, 0, -1);   // add
        run(6'b100011, 6'b000000, 1'b0, 2, 3, -1);   // lw with stalls
        run(6'b000100, 6'b000000, 1'b1, 0, 0, -1);   // beq taken
        run(6'b000100, 6'b000000, 1'b0, 0, 0, -1);   // beq not taken
        run(6'b000011, 6'b000000, 1'b0, 0, 0, -1);   // jal
        run(6'b000000, 6'b001000, 1'b0, 0, 0, -1);   // jr
        run(6'b000010, 6'b000000, 1'b0, 1, 0, -1);   // j
        run(6'b101011, 6'b000000, 1'b0, 0, 1, -1);   // sw
        run(6'b001010, 6'b000000, 1'b0, 0, 0, -1);   // slti
        run(6'b111111, 6'b000000, 1'b0, 0, 0, -1);   // illegal opcode
        run(6'b000000, 6'b000111, 1'b0, 0, 0, -1);   // illegal funct
        run(6'b101011, 6'b000000, 1'b0, 0, 3, 4);    // reset in MEM_WR stall
        run(6'b000000, 6'b100010, 1'b0, 0, 0, -1);   // sub after abort

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(N_OPS - 1)];
            fn = fns[$urandom_range(N_FNS - 1)];
            if ($urandom_range(15) == 0) op = 6'(6'b110000 | 6'($urandom_range(15)));
            if ($urandom_range(15) == 0) fn = 6'($urandom_range(7));
            run(op, fn, 1'($urandom), $urandom_range(3), $urandom_range(3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle MIPS datapath built from the shared utility blocks: registers, 2:1/3:1 muxes, adder, sign extender and shifters. It fetches and decodes each instruction and sequences the datapath through 3–5 states per instruction. It drives every mux select, register load, memory strobe and ALU function, and stalls on a memory ready handshake. Unknown opcodes trap into a sticky halt.

## Interface
Parameters:
- none; widths fixed by the 32-bit MIPS datapath

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_ld  out  1  PC register load
- pc_src  out  2  PC mux: 00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}, 11 reg A
- i_or_d  out  1  address mux: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load
- reg_dst  out  2  write-register mux: 00 rt, 01 rd, 10 constant 31
- mem_to_reg  out  2  write-data mux: 00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm << 2
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- halted  out  1  high in HALT
- state  out  4  current state, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BRANCH 8, JUMP 9, I_EX 10, I_WB 11, JAL 12, JR 13, HALT 14.
- Every output not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add.
  - If mem_ready: ir_write=1, pc_ld=1 (pc_src=00), go to DECODE.
  - Otherwise hold in FETCH with no IR or PC load.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_ctrl=add, computing the branch target into ALUOut.
  - Dispatch on opcode:
    - 000000 with funct 001000 → JR
    - any other 000000 → R_EX
    - 100011 lw and 101011 sw → MEM_ADDR
    - 000100 beq → BRANCH
    - 001000 addi and 001010 slti → I_EX
    - 000010 j → JUMP
    - 000011 jal → JAL
    - anything else → HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- R_EX: alu_src_a=1, alu_src_b=00. alu_ctrl from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - any other funct → go to HALT instead of R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, then FETCH.
- I_EX: alu_src_a=1, alu_src_b=10, alu_ctrl add (addi) or slt (slti), then I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_ld=zero, then FETCH.
- JUMP: pc_src=10, pc_ld=1, then FETCH.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4); pc_src=10, pc_ld=1; then FETCH.
- JR: pc_src=11, pc_ld=1, then FETCH.
- HALT: halted=1, all strobes 0. Sticky until rst.

## Timing
- The state register updates on the rising edge of clk.
- Outputs are decoded combinationally from state. Only ir_write and pc_ld also depend on mem_ready (FETCH) or zero (BRANCH).
- While rst=1: state is forced to FETCH at the next edge, and every output except `state` is forced to 0, including mem_read and halted.
- The first fetch occurs in the cycle after rst deasserts.
- Cycle counts with mem_ready held high: R-type 4, lw 5, sw 4, addi/slti 4, beq 3, j 3, jal 3, jr 3.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory strobes stay asserted and stable through a stall.
- mem_ready is ignored in all other states.
- rst asserted mid-instruction (including during a stall or in HALT) aborts that instruction with no further register or memory write.

## Test plan
- Reset release, then R-type add (opcode 000000, funct 100000) with mem_ready=1 → states 0,1,6,7,0; alu_ctrl=010 in R_EX; reg_write=1, reg_dst=01 for exactly one cycle.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 in MEM_RD → 10 cycles total; ir_write pulses once; mem_read and i_or_d=1 are stable through the stall; reg_write with mem_to_reg=01 in state 4.
- beq (000100) with zero=1, then with zero=0 → pc_ld=1 with pc_src=01 in BRANCH only when zero=1; 3 cycles each.
- jal (000011) → JAL asserts reg_write, reg_dst=10, mem_to_reg=10, pc_ld=1, pc_src=10 in the same cycle. jr (funct 001000) → pc_src=11.
- Opcode 111111, and R-type funct 000111 → enter state 14 with halted=1; stays there for 20 cycles with all strobes 0; rst returns to FETCH.
- rst pulsed during MEM_WR stall → mem_write drops in the reset cycle; FETCH follows; no write is observed.
